// File: rtl/chimp_board_engine.sv
// chimp_board_engine
//   Board engine for the chimp memory test. On start it clears a GRID_W x GRID_H
//   board one cell per cycle, scatters the numbers 1..L over random free cells
//   (retrying on collisions), then judges the order of the player's clicks.
//
// Ports
//   clk, iResetn            clock, async active-low reset
//   iStart, iLevel          round start (IDLE only) and number count L
//   iRandNum                free-running random source, low bits pick the cell
//   iClick, iClickX/Y       one-cycle click pulse and clicked cell
//   iCellX/Y                renderer read address
//   oCellActive/Shown/Num   combinational read of the addressed cell
//   oBusy, oPlaying         CLEAR/PLACE and PLAY status
//   oNextNum                number the player must click next
//   oRoundWin/oRoundFail    one-cycle outcome pulses
`timescale 1ns/1ps

// One board cell: active flag plus stored number.
module chimp_cell #(
  parameter int NUM_W = 5
) (
  input  logic             clk,
  input  logic             iResetn,
  input  logic             we,
  input  logic             wact,
  input  logic [NUM_W-1:0] wnum,
  output logic             act,
  output logic [NUM_W-1:0] num
);
  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      act <= 1'b0;
      num <= '0;
    end else if (we) begin
      act <= wact;
      num <= wnum;
    end
  end
endmodule

module chimp_board_engine #(
  parameter int GRID_W  = 8,
  parameter int GRID_H  = 8,
  parameter int MAX_NUM = 31,
  parameter int RAND_W  = 8,
  localparam int XW     = $clog2(GRID_W),
  localparam int YW     = $clog2(GRID_H),
  localparam int NUM_W  = $clog2(MAX_NUM + 1)
) (
  input  logic              clk,
  input  logic              iResetn,
  input  logic              iStart,
  input  logic [NUM_W-1:0]  iLevel,
  input  logic [RAND_W-1:0] iRandNum,
  input  logic              iClick,
  input  logic [XW-1:0]     iClickX,
  input  logic [YW-1:0]     iClickY,
  input  logic [XW-1:0]     iCellX,
  input  logic [YW-1:0]     iCellY,
  output logic              oCellActive,
  output logic              oCellShown,
  output logic [NUM_W-1:0]  oCellNum,
  output logic              oBusy,
  output logic              oPlaying,
  output logic [NUM_W-1:0]  oNextNum,
  output logic              oRoundWin,
  output logic              oRoundFail
);
  localparam int NCELL = GRID_W * GRID_H;
  localparam int IW    = XW + YW;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_PLACE, S_PLAY, S_WIN, S_FAIL} state_t;

  state_t                       state, state_n;
  logic [NCELL-1:0]             act;
  logic [NCELL-1:0][NUM_W-1:0]  num;
  logic                         hidden;
  logic [NUM_W-1:0]             next_num, lvl, lvl_c, place_num;
  logic [IW-1:0]                clr_idx;

  // Grid dimensions are powers of two, so {y,x} is the linear index y*GRID_W+x.
  logic [IW-1:0] rd_idx, pl_idx, ck_idx;
  assign rd_idx = {iCellY, iCellX};
  assign ck_idx = {iClickY, iClickX};
  assign pl_idx = iRandNum[IW-1:0];

  generate
    if (RAND_W > IW) begin : g_rand_hi
      logic unused_rand;
      assign unused_rand = ^iRandNum[RAND_W-1:IW];
    end
  endgenerate

  // Write port shared by clear, place and click-consume.
  logic             wr_en, wr_act;
  logic [IW-1:0]    wr_idx;
  logic [NUM_W-1:0] wr_num;
  logic             start, clr_inc, plc_inc, nxt_inc, hid_set, hid_clr;

  always_comb begin
    // Extra top bit keeps the comparison meaningful when iLevel cannot exceed MAX_NUM.
    if (iLevel == '0)
      lvl_c = NUM_W'(1);
    else if ({1'b0, iLevel} > (NUM_W+1)'(MAX_NUM))
      lvl_c = NUM_W'(MAX_NUM);
    else
      lvl_c = iLevel;
  end

  always_comb begin
    state_n = state;
    wr_en   = 1'b0;
    wr_act  = 1'b0;
    wr_idx  = clr_idx;
    wr_num  = '0;
    start   = 1'b0;
    clr_inc = 1'b0;
    plc_inc = 1'b0;
    nxt_inc = 1'b0;
    hid_set = 1'b0;
    hid_clr = 1'b0;
    case (state)
      S_IDLE: if (iStart) begin
        start   = 1'b1;
        state_n = S_CLEAR;
      end
      S_CLEAR: begin
        wr_en   = 1'b1;
        clr_inc = 1'b1;
        if (clr_idx == IW'(NCELL - 1)) state_n = S_PLACE;
      end
      S_PLACE: if (!act[pl_idx]) begin
        wr_en   = 1'b1;
        wr_idx  = pl_idx;
        wr_act  = 1'b1;
        wr_num  = place_num;
        plc_inc = 1'b1;
        if (place_num == lvl) state_n = S_PLAY;
      end
      S_PLAY: if (iClick && act[ck_idx]) begin
        if (num[ck_idx] == next_num) begin
          // Consume the cell; its number stays stored but reads as 0.
          wr_en   = 1'b1;
          wr_idx  = ck_idx;
          wr_num  = num[ck_idx];
          hid_set = 1'b1;
          nxt_inc = 1'b1;
          if (next_num == lvl) state_n = S_WIN;
        end else begin
          // Reveal what is left so the player sees the correct layout.
          hid_clr = 1'b1;
          state_n = S_FAIL;
        end
      end
      S_WIN, S_FAIL: state_n = S_IDLE;
      default:       state_n = S_IDLE;
    endcase
  end

  generate
    for (genvar g = 0; g < NCELL; g++) begin : g_cell
      chimp_cell #(.NUM_W(NUM_W)) u_cell (
        .clk     (clk),
        .iResetn (iResetn),
        .we      (wr_en && (wr_idx == IW'(g))),
        .wact    (wr_act),
        .wnum    (wr_num),
        .act     (act[g]),
        .num     (num[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      state     <= S_IDLE;
      hidden    <= 1'b0;
      next_num  <= NUM_W'(1);
      lvl       <= '0;
      place_num <= '0;
      clr_idx   <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        lvl       <= lvl_c;
        hidden    <= 1'b0;
        next_num  <= NUM_W'(1);
        place_num <= NUM_W'(1);
        clr_idx   <= '0;
      end
      if (clr_inc) clr_idx   <= clr_idx + IW'(1);
      if (plc_inc) place_num <= place_num + NUM_W'(1);
      if (nxt_inc) next_num  <= next_num + NUM_W'(1);
      if (hid_set) hidden    <= 1'b1;
      if (hid_clr) hidden    <= 1'b0;
    end
  end

  assign oCellActive = act[rd_idx];
  assign oCellShown  = act[rd_idx] & ~hidden;
  assign oCellNum    = act[rd_idx] ? num[rd_idx] : '0;
  assign oBusy       = (state == S_CLEAR) || (state == S_PLACE);
  assign oPlaying    = (state == S_PLAY);
  assign oNextNum    = next_num;
  assign oRoundWin   = (state == S_WIN);
  assign oRoundFail  = (state == S_FAIL);
endmodule

// File: tb/tb_chimp_board_engine.sv
`timescale 1ns/1ps
module tb_chimp_board_engine;
  localparam int NC = 64;

  logic       clk = 1'b0;
  logic       iResetn, iStart, iClick;
  logic [4:0] iLevel;
  logic [7:0] iRandNum;
  logic [2:0] iClickX, iClickY, iCellX, iCellY;
  logic       oCellActive, oCellShown, oBusy, oPlaying, oRoundWin, oRoundFail;
  logic [4:0] oCellNum, oNextNum;

  always #5 clk = ~clk;

  chimp_board_engine #(.GRID_W(8), .GRID_H(8), .MAX_NUM(31), .RAND_W(8)) dut (
    .clk(clk), .iResetn(iResetn), .iStart(iStart), .iLevel(iLevel),
    .iRandNum(iRandNum), .iClick(iClick), .iClickX(iClickX), .iClickY(iClickY),
    .iCellX(iCellX), .iCellY(iCellY), .oCellActive(oCellActive),
    .oCellShown(oCellShown), .oCellNum(oCellNum), .oBusy(oBusy),
    .oPlaying(oPlaying), .oNextNum(oNextNum), .oRoundWin(oRoundWin),
    .oRoundFail(oRoundFail)
  );

  int checks = 0, errors = 0;

  // Reference model: board as plain arrays, rules applied per event.
  int m_act[NC], m_num[NC];
  int m_hid, m_next, m_lvl, m_placed;
  bit m_play;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin m_act[i] = 0; m_num[i] = 0; end
    m_hid = 0; m_next = 1; m_lvl = 0; m_placed = 0; m_play = 0;
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_busy"}, oBusy, 0);
    chk({nm, "_playing"}, oPlaying, 0);
    chk({nm, "_win"}, oRoundWin, 0);
    chk({nm, "_fail"}, oRoundFail, 0);
    chk({nm, "_next"}, oNextNum, m_next & 31);
  endtask

  // Only called while the DUT is in a stable state (IDLE, or PLAY without a click).
  task automatic check_board();
    int exp, got;
    for (int i = 0; i < NC; i++) begin
      iCellX = 3'(i % 8); iCellY = 3'(i / 8);
      #1;
      exp = m_act[i] ? (64 + (m_hid ? 0 : 32) + m_num[i]) : 0;
      got = {25'd0, oCellActive, oCellShown, oCellNum};
      chk($sformatf("cell%0d_act_shown_num", i), got, exp);
    end
  endtask

  task automatic start_round(input int lvl);
    iLevel = 5'(lvl); iStart = 1'b1; iRandNum = 8'($urandom);
    tick();
    iStart = 1'b0;
    m_lvl = (lvl == 0) ? 1 : (lvl > 31 ? 31 : lvl);
    m_hid = 0; m_next = 1; m_placed = 0; m_play = 0;
    chk("busy_after_start", oBusy, 1);
    // 64 clear cycles; random input here must not place anything.
    for (int k = 0; k < 64; k++) begin
      iRandNum = 8'($urandom);
      tick();
      chk("busy_clear", oBusy, 1);
      chk("playing_clear", oPlaying, 0);
    end
    for (int i = 0; i < NC; i++) begin m_act[i] = 0; m_num[i] = 0; end
  endtask

  task automatic place_step(input int r);
    int idx;
    iRandNum = 8'(r);
    tick();
    idx = r % 64;
    if (!m_act[idx] && m_placed < m_lvl) begin
      m_placed++;
      m_act[idx] = 1;
      m_num[idx] = m_placed;
    end
    if (m_placed == m_lvl) m_play = 1;
    chk("busy_place", oBusy, m_play ? 0 : 1);
    chk("playing_place", oPlaying, m_play ? 1 : 0);
  endtask

  task automatic place_random();
    int n = 0;
    while (!m_play && n < 3000) begin
      place_step(int'($urandom_range(0, 255)));
      n++;
    end
    if (!m_play) chk("place_timeout", 0, 1);
  endtask

  task automatic do_click(input int idx);
    int w = 0, f = 0;
    iClickX = 3'(idx % 8); iClickY = 3'(idx / 8); iClick = 1'b1;
    tick();
    iClick = 1'b0;
    if (m_play && m_act[idx]) begin
      if (m_num[idx] == m_next) begin
        m_act[idx] = 0; m_hid = 1;
        if (m_next == m_lvl) begin w = 1; m_play = 0; end
        m_next++;
      end else begin
        m_hid = 0; f = 1; m_play = 0;
      end
    end
    chk("click_win", oRoundWin, w);
    chk("click_fail", oRoundFail, f);
    chk("click_playing", oPlaying, m_play ? 1 : 0);
    chk("click_next", oNextNum, m_next & 31);
    if (w || f) begin
      tick();
      check_idle("after_outcome");
    end
  endtask

  task automatic build_board();
    start_round(2);
    place_step(8'h00);
    place_step(8'h00);
    place_step(8'h09);
  endtask

  typedef struct {
    bit rebuild; bit click; int x; int y;
    int play; int nxt; int win; int fail; int a00; int s00; int a11; int s11;
  } vec_t;

  vec_t vt[10];

  initial begin
    int p, n, w, f, a00, s00, a11, s11;

    vt[0] = '{1, 0, 0, 0, 1, 1, 0, 0, 1, 1, 1, 1};
    vt[1] = '{0, 1, 3, 3, 1, 1, 0, 0, 1, 1, 1, 1};
    vt[2] = '{0, 1, 0, 0, 1, 2, 0, 0, 0, 0, 1, 0};
    vt[3] = '{0, 1, 1, 1, 0, 3, 1, 0, 0, 0, 0, 0};
    vt[4] = '{0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0};
    vt[5] = '{1, 0, 0, 0, 1, 1, 0, 0, 1, 1, 1, 1};
    vt[6] = '{0, 1, 3, 3, 1, 1, 0, 0, 1, 1, 1, 1};
    vt[7] = '{0, 1, 1, 1, 0, 1, 0, 1, 1, 1, 1, 1};
    vt[8] = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1};
    vt[9] = '{0, 1, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1};

    iResetn = 1'b0; iStart = 1'b0; iClick = 1'b0; iLevel = '0; iRandNum = '0;
    iClickX = '0; iClickY = '0; iCellX = '0; iCellY = '0;
    model_reset();

    // Reset state
    #23;
    check_idle("reset");
    iResetn = 1'b1;
    tick();
    check_idle("post_reset");
    check_board();

    // Reset in the middle of PLACE discards the partial board
    start_round(5);
    place_step(int'($urandom_range(0, 255)));
    place_step(int'($urandom_range(0, 255)));
    #2 iResetn = 1'b0;
    #1;
    model_reset();
    check_idle("async_reset");
    #10 iResetn = 1'b1;
    tick();
    check_idle("reset_release");
    check_board();

    // Directed vectors on the fixed board (0,0)=1, (1,1)=2
    for (int i = 0; i < 10; i++) begin
      if (vt[i].rebuild) build_board();
      else begin
        iClick = vt[i].click; iClickX = 3'(vt[i].x); iClickY = 3'(vt[i].y);
        tick();
        iClick = 1'b0;
      end
      p = oPlaying; n = oNextNum; w = oRoundWin; f = oRoundFail;
      iCellX = 3'd0; iCellY = 3'd0; #0.5;
      a00 = oCellActive; s00 = oCellShown;
      iCellX = 3'd1; iCellY = 3'd1; #0.5;
      a11 = oCellActive; s11 = oCellShown;
      chk($sformatf("vec%0d_playing", i), p, vt[i].play);
      chk($sformatf("vec%0d_next", i), n, vt[i].nxt);
      chk($sformatf("vec%0d_win", i), w, vt[i].win);
      chk($sformatf("vec%0d_fail", i), f, vt[i].fail);
      chk($sformatf("vec%0d_act00", i), a00, vt[i].a00);
      chk($sformatf("vec%0d_shown00", i), s00, vt[i].s00);
      chk($sformatf("vec%0d_act11", i), a11, vt[i].a11);
      chk($sformatf("vec%0d_shown11", i), s11, vt[i].s11);
    end

    // Randomized rounds against the model
    for (int r = 0; r < 8; r++) begin
      int lvl, guard;
      lvl = (r == 0) ? 0 : (r == 1) ? 31 : (r == 2) ? 2 : int'($urandom_range(1, 31));
      start_round(lvl);
      place_random();
      check_board();
      guard = 0;
      while (m_play && guard < 300) begin
        int sel, tgt;
        int q[$];
        guard++;
        sel = int'($urandom_range(0, 39));
        q.delete();
        if (sel == 0) begin
          iStart = 1'b1; iLevel = 5'($urandom);
          tick();
          iStart = 1'b0;
          chk("start_in_play_playing", oPlaying, 1);
          chk("start_in_play_busy", oBusy, 0);
          chk("start_in_play_next", oNextNum, m_next & 31);
          continue;
        end
        if (sel <= 6) begin
          for (int i = 0; i < NC; i++) if (!m_act[i]) q.push_back(i);
        end else if (sel == 7) begin
          for (int i = 0; i < NC; i++) if (m_act[i] && m_num[i] != m_next) q.push_back(i);
        end
        if (q.size() == 0)
          for (int i = 0; i < NC; i++) if (m_act[i] && m_num[i] == m_next) q.push_back(i);
        tgt = q[$urandom_range(0, q.size() - 1)];
        do_click(tgt);
        check_board();
      end
      if (m_play) chk("play_timeout", 0, 1);
      // A click in IDLE must be ignored
      do_click(int'($urandom_range(0, NC - 1)));
      check_board();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
